// File: rtl/fdct_pkg.sv
// Shared definitions for the forward-DCT row stage: FSM state encoding,
// cosine table format, sample and accumulator widths and the 8x8 cosine table.
// COEF[k][n] = round(2^COEF_FRAC * C(k)/2 * cos((2n+1)k*pi/16)), C(0) = 1/sqrt2.
package fdct_pkg;

    localparam int COEF_FRAC = 8;
    localparam int COEF_W    = COEF_FRAC + 1;
    localparam int SAMPLE_W  = 9;
    localparam int ACC_W     = SAMPLE_W + COEF_FRAC + 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPUTE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic signed [COEF_W-1:0] COEF [8][8] = '{
        '{ 9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91 },
        '{ 9'sd126,  9'sd106,  9'sd71,   9'sd25,  -9'sd25,  -9'sd71,  -9'sd106, -9'sd126 },
        '{ 9'sd118,  9'sd49,  -9'sd49,  -9'sd118, -9'sd118, -9'sd49,   9'sd49,   9'sd118 },
        '{ 9'sd106, -9'sd25,  -9'sd126, -9'sd71,   9'sd71,   9'sd126,  9'sd25,  -9'sd106 },
        '{ 9'sd91,  -9'sd91,  -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91 },
        '{ 9'sd71,  -9'sd126,  9'sd25,   9'sd106, -9'sd106, -9'sd25,   9'sd126, -9'sd71 },
        '{ 9'sd49,  -9'sd118,  9'sd118, -9'sd49,  -9'sd49,   9'sd118, -9'sd118,  9'sd49 },
        '{ 9'sd25,  -9'sd71,   9'sd106, -9'sd126,  9'sd126, -9'sd106,  9'sd71,  -9'sd25 }
    };

endpackage

// File: rtl/fdct_round_sat.sv
// Combinational scaling of a DCT accumulator back to coefficient units:
// drop COEF_FRAC fraction bits rounding half away from zero, then clamp to
// the signed OUT_W range. Internal width is chosen so neither the negation
// nor the rounding increment can overflow for any OUT_W.
module fdct_round_sat
    import fdct_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] q
);

    localparam int RW = (ACC_W + 2 > OUT_W + 1) ? ACC_W + 2 : OUT_W + 1;
    localparam logic signed [RW-1:0] HALF  = RW'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [RW-1:0] Q_MAX = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] Q_MIN = -(RW'(1) <<< (OUT_W - 1));

    logic signed [RW-1:0] wide;
    logic signed [RW-1:0] mag;
    logic signed [RW-1:0] rnd;

    // Round the magnitude, restore the sign, then saturate.
    always_comb begin
        wide = RW'(acc);
        mag  = (wide < 0) ? -wide : wide;
        rnd  = (mag + HALF) >>> COEF_FRAC;
        if (wide < 0) begin
            rnd = -rnd;
        end
        if (rnd > Q_MAX) begin
            q = Q_MAX[OUT_W-1:0];
        end else if (rnd < Q_MIN) begin
            q = Q_MIN[OUT_W-1:0];
        end else begin
            q = rnd[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fdct_row_stage.sv
// First (row) pass of the JPEG forward 8-point DCT. Collects eight pixels,
// computes one coefficient per cycle from the cosine table and presents the
// packed row (X(0) in the MSBs) until the column pass accepts it.
// Build option FDCT_LEVEL_SHIFT_EN: in_pix is unsigned and 128 is subtracted
// on entry; otherwise in_pix is already a signed two's-complement sample.
//
// state   | meaning
// IDLE    | one cycle after reset, nothing accepted
// COLLECT | in_ready high, pixels written to pix_buf[n_cnt]
// COMPUTE | eight cycles, slot X(k_cnt) of the row register written each cycle
// HOLD    | out_valid high, row stable until out_ready
module fdct_row_stage
    import fdct_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_pix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*OUT_W-1:0] out_row
);

    state_t                     state;
    logic [2:0]                 n_cnt;
    logic [2:0]                 k_cnt;
    logic signed [SAMPLE_W-1:0] pix_buf [8];
    logic [8*OUT_W-1:0]         row_q;
    logic signed [SAMPLE_W-1:0] sample;
    logic signed [ACC_W-1:0]    acc;
    logic signed [OUT_W-1:0]    coef_q;

`ifdef FDCT_LEVEL_SHIFT_EN
    assign sample = $signed({1'b0, in_pix}) - 9'sd128;
`else
    assign sample = $signed({in_pix[7], in_pix});
`endif

    // All eight products for the current k are summed in one cycle.
    always_comb begin
        acc = '0;
        for (int n = 0; n < 8; n++) begin
            acc = acc + ACC_W'(pix_buf[n]) * ACC_W'(COEF[k_cnt][n]);
        end
    end

    fdct_round_sat #(
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc (acc),
        .q   (coef_q)
    );

    // Sequencing FSM, pixel buffer and output row register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            n_cnt <= '0;
            k_cnt <= '0;
            row_q <= '0;
            for (int i = 0; i < 8; i++) begin
                pix_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= COLLECT;
                end
                COLLECT: begin
                    if (in_valid) begin
                        pix_buf[n_cnt] <= sample;
                        if (n_cnt == 3'd7) begin
                            n_cnt <= '0;
                            state <= COMPUTE;
                        end else begin
                            n_cnt <= n_cnt + 3'd1;
                        end
                    end
                end
                COMPUTE: begin
                    row_q[(7 - int'(k_cnt)) * OUT_W +: OUT_W] <= coef_q;
                    if (k_cnt == 3'd7) begin
                        k_cnt <= '0;
                        state <= HOLD;
                    end else begin
                        k_cnt <= k_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= COLLECT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign out_row   = row_q;

endmodule

// File: tb/tb_fdct_row_stage.sv
// Self-checking bench for fdct_row_stage. The reference derives the cosine
// table from the DCT formula with real arithmetic, forms exact integer sums
// and rounds half away from zero; results are also compared with the
// floating-point DCT. Works in both level-shift builds: samples x(n) are
// encoded onto in_pix according to FDCT_LEVEL_SHIFT_EN.
module tb_fdct_row_stage;

    localparam int OUT_W = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_pix = 8'd0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [8*OUT_W-1:0] out_row;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int  xs [8];
    int  coef_m [8][8];
    int  exp_q [8];
    real flt [8];
    logic [8*OUT_W-1:0] last_row;

    fdct_row_stage #(
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix_code(input int x);
`ifdef FDCT_LEVEL_SHIFT_EN
        return 8'(x + 128);
`else
        return 8'(x);
`endif
    endfunction

    function automatic int rand_x();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic init_model();
        real pi, ck, v;
        pi = 3.14159265358979323846;
        for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            for (int n = 0; n < 8; n++) begin
                v = 256.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0);
                coef_m[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
        end
    endtask

    task automatic compute_model();
        real pi, ck;
        longint acc;
        int q;
        pi = 3.14159265358979323846;
        for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            acc = 0;
            flt[k] = 0.0;
            for (int n = 0; n < 8; n++) begin
                acc = acc + longint'(xs[n] * coef_m[k][n]);
                flt[k] = flt[k] + real'(xs[n]) * ck / 2.0 *
                         $cos(real'((2 * n + 1) * k) * pi / 16.0);
            end
            q = (acc >= 0) ? int'((acc + 128) / 256) : -int'((-acc + 128) / 256);
            if (q > 2047) q = 2047;
            if (q < -2048) q = -2048;
            exp_q[k] = q;
        end
    endtask

    // C(0)/2 quantises to 91/256, so DC may sit up to about 2 LSB from the exact DCT.
    task automatic check_row(input string name, input logic [8*OUT_W-1:0] r);
        logic signed [OUT_W-1:0] c;
        int  got;
        real d;
        for (int k = 0; k < 8; k++) begin
            c = r[(7 - k) * OUT_W +: OUT_W];
            got = int'(c);
            checks++;
            if (got !== exp_q[k]) begin
                errors++;
                $display("FAIL %s X%0d got %0d want %0d", name, k, got, exp_q[k]);
            end
            d = real'(got) - flt[k];
            checks++;
            if (d > 2.5 || d < -2.5) begin
                errors++;
                $display("FAIL %s X%0d_float got %0d want %f", name, k, got, flt[k]);
            end
        end
    endtask

    task automatic send_pix(input int x, output int cap_cyc);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_pix = pix_code(x);
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_timeout got %b want 1", in_ready);
        end
        cap_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_row(input string name, input int gap_max, input int hold, input bit chk_lat);
        int lat, cap, g;
        logic [8*OUT_W-1:0] ref_row;
        for (int n = 0; n < 8; n++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
            repeat (g) @(negedge clk);
            send_pix(xs[n], cap);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid_timeout got %b want 1", name, out_valid);
        end
        if (chk_lat) begin
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL %s latency got %0d want 9", name, lat);
            end
        end
        ref_row = out_row;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (out_row !== ref_row || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s hold_cycle%0d got row=%h rdy=%b vld=%b want row=%h rdy=0 vld=1",
                         name, i, out_row, in_ready, out_valid, ref_row);
            end
        end
        last_row = out_row;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_handshake got vld=%b rdy=%b want vld=0 rdy=1",
                     name, out_valid, in_ready);
        end
        compute_model();
        check_row(name, last_row);
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_row !== '0) begin
            errors++;
            $display("FAIL %s reset_outputs got rdy=%b vld=%b row=%h want 0 0 0",
                     name, in_ready, out_valid, out_row);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_row !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b row=%h want 0 0 0",
                     in_ready, out_valid, out_row);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL collect_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_all_mid();
        for (int n = 0; n < 8; n++) xs[n] = 0;
        run_row("all128", 0, 0, 1'b1);
        checks++;
        if (last_row !== '0) begin
            errors++;
            $display("FAIL all128_zero got %h want 0", last_row);
        end
    endtask

    task automatic test_all_max();
        for (int n = 0; n < 8; n++) xs[n] = 127;
        run_row("all255", 0, 0, 1'b1);
    endtask

    task automatic test_impulse();
        logic signed [OUT_W-1:0] c0, c1;
        for (int n = 0; n < 8; n++) xs[n] = 0;
        xs[0] = 127;
        run_row("impulse", 0, 0, 1'b1);
        c0 = last_row[7 * OUT_W +: OUT_W];
        c1 = last_row[6 * OUT_W +: OUT_W];
        checks++;
        if (c0 !== 12'sd45 || c1 !== 12'sd63) begin
            errors++;
            $display("FAIL impulse_x0x1 got %0d %0d want 45 63", c0, c1);
        end
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 8; n++) xs[n] = rand_x();
        run_row("backpressure", 0, 20, 1'b1);
        for (int n = 0; n < 8; n++) xs[n] = rand_x();
        run_row("after_backpressure", 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int cap;
        for (int n = 0; n < 5; n++) send_pix(rand_x(), cap);
        pulse_reset("reset_partial");
        for (int n = 0; n < 8; n++) xs[n] = rand_x();
        run_row("after_reset_partial", 0, 0, 1'b1);
        for (int n = 0; n < 8; n++) send_pix(rand_x(), cap);
        repeat (3) @(negedge clk);
        pulse_reset("reset_compute");
        for (int n = 0; n < 8; n++) xs[n] = rand_x();
        run_row("after_reset_compute", 0, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            for (int n = 0; n < 8; n++) xs[n] = rand_x();
            run_row($sformatf("random%0d", r), 3, int'($urandom_range(3)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int row_a [8];
        int row_b [8];
        int cap_a, cap_b, cap_tmp, t;
        logic [8*OUT_W-1:0] got_a, got_b;
        cap_a = 0;
        cap_b = 0;
        got_a = '0;
        got_b = '0;
        for (int n = 0; n < 8; n++) begin
            row_a[n] = rand_x();
            row_b[n] = rand_x();
        end
        out_ready = 1'b1;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    send_pix(row_a[n], cap_tmp);
                    if (n == 0) cap_a = cap_tmp;
                end
                for (int n = 0; n < 8; n++) begin
                    send_pix(row_b[n], cap_tmp);
                    if (n == 0) cap_b = cap_tmp;
                end
            end
            begin
                t = 0;
                while (out_valid !== 1'b1 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                got_a = out_row;
                @(negedge clk);
                t = 0;
                while (out_valid !== 1'b1 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                got_b = out_row;
                @(negedge clk);
            end
        join
        out_ready = 1'b0;
        checks++;
        if (cap_b - cap_a !== 17) begin
            errors++;
            $display("FAIL b2b_period got %0d want 17", cap_b - cap_a);
        end
        for (int n = 0; n < 8; n++) xs[n] = row_a[n];
        compute_model();
        check_row("b2b_a", got_a);
        for (int n = 0; n < 8; n++) xs[n] = row_b[n];
        compute_model();
        check_row("b2b_b", got_b);
    endtask

    initial begin
        init_model();
        test_reset();
        test_all_mid();
        test_all_max();
        test_impulse();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
